cmp_share_arbiter: RTL and testbench



---
 rtl/cmp_share_pkg.sv | 22 ++
 rtl/cmp_rr_pick.sv | 29 ++
 rtl/cmp_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_share_pkg.sv
// Shared types and constants for the compare-share arbiter.
// Optional statistics counter is enabled with CMP_SHARE_ARBITER_STATS_EN.
package cmp_share_pkg;

    // Arbiter FSM states; encoding is fixed so the state can be probed directly.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } cmp_state_t;

    // Magnitude-compare outcome; exactly one bit is set for a valid result.
    typedef struct packed {
        logic equal;
        logic bigger;
        logic less;
    } cmp_result_t;

    // Width of the optional handshake counter.
    localparam int CMP_STATS_W = 16;

endpackage

// File: rtl/cmp_rr_pick.sv
// Round-robin winner search: first set request bit strictly after rr_ptr,
// wrapping modulo N. Purely combinational.
module cmp_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic           any,
    output logic [IDW-1:0] win_id
);

    // Walk the N positions after rr_ptr; the first pending request wins.
    always_comb begin
        int             pos;
        logic [IDW-1:0] idx;
        any    = 1'b0;
        win_id = '0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(rr_ptr) + k) % N;
            idx = IDW'(pos);
            if (!any && req[idx]) begin
                any    = 1'b1;
                win_id = idx;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one unsigned W-bit magnitude comparator among N requesters.
// Round-robin arbitration, one comparison in flight, result returned on a
// valid/ready channel. Define CMP_SHARE_ARBITER_STATS_EN to add cmp_count.
//
// Response handshake: rsp_valid rises with a new result and, together with
// rsp_id and the result fields, stays stable until the cycle in which
// rsp_ready is also high; that edge is the transfer. rsp_ready is ignored
// while rsp_valid is low.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         a_in,
    input  logic [N*W-1:0]         b_in,
    output logic [N-1:0]           gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_equal,
    output logic                   rsp_bigger,
    output logic                   rsp_less
`ifdef CMP_SHARE_ARBITER_STATS_EN
    ,
    output logic [CMP_STATS_W-1:0] cmp_count
`endif
);

    localparam logic [N-1:0] GNT_ONE = N'(1);

    cmp_state_t     state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] rr_ptr;
    cmp_result_t    rsp_q;

    logic           pick_any;
    logic [IDW-1:0] pick_id;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    cmp_result_t    cmp_now;

    cmp_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .win_id (pick_id)
    );

    // Route the winning requester's operand lanes to the capture registers.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == pick_id) begin
                sel_a = a_in[i*W +: W];
                sel_b = b_in[i*W +: W];
            end
        end
    end

    // Unsigned compare of the captured operands.
    always_comb begin
        cmp_now.equal  = (op_a == op_b);
        cmp_now.bigger = (op_a >  op_b);
        cmp_now.less   = (op_a <  op_b);
    end

    // Arbitration / compare / respond sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cur_id    <= '0;
            rr_ptr    <= IDW'(N - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        cur_id <= pick_id;
                        gnt    <= GNT_ONE << pick_id;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    rsp_q     <= cmp_now;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                    state     <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= cur_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign rsp_equal  = rsp_q.equal;
    assign rsp_bigger = rsp_q.bigger;
    assign rsp_less   = rsp_q.less;

`ifdef CMP_SHARE_ARBITER_STATS_EN
    logic [CMP_STATS_W-1:0] stat_cnt;

    // Saturating count of completed response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (rsp_valid && rsp_ready && (stat_cnt != {CMP_STATS_W{1'b1}})) begin
            stat_cnt <= stat_cnt + 1'b1;
        end
    end

    assign cmp_count = stat_cnt;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed vector table,
// hand-written multi-cycle sequences and randomized transactions checked
// against a round-robin / compare reference model.
module tb_cmp_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_equal;
    logic             rsp_bigger;
    logic             rsp_less;
`ifdef CMP_SHARE_ARBITER_STATS_EN
    logic [15:0]      cmp_count;
`endif

    int total = 0;
    int bad   = 0;
    int model_last;

    // Clock
    always #5 clk = ~clk;

    cmp_share_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_equal  (rsp_equal),
        .rsp_bigger (rsp_bigger),
        .rsp_less   (rsp_less)
`ifdef CMP_SHARE_ARBITER_STATS_EN
        ,
        .cmp_count  (cmp_count)
`endif
    );

    typedef struct {
        logic [N-1:0] r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           id;
        logic         e;
        logic         g;
        logic         l;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rand_lanes();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    function automatic logic [N*W-1:0] put_lane(input logic [N*W-1:0] v, input int id, input logic [W-1:0] x);
        logic [N*W-1:0] o;
        o = v;
        for (int i = 0; i < N; i++) if (i == id) o[i*W +: W] = x;
        return o;
    endfunction

    function automatic logic [W-1:0] get_lane(input logic [N*W-1:0] v, input int id);
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i < N; i++) if (i == id) x = v[i*W +: W];
        return x;
    endfunction

    // Reference arbitration: among pending requesters, the one at the
    // smallest clockwise distance past the last winner.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        int best;
        int best_d;
        best   = -1;
        best_d = N + 1;
        for (int i = 0; i < N; i++) begin
            if (r[i] && (((i - last - 1 + 2 * N) % N) < best_d)) begin
                best   = i;
                best_d = (i - last - 1 + 2 * N) % N;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (i == id) v[i] = 1'b1;
        return v;
    endfunction

    // Driver: one complete transaction starting from IDLE at a negedge.
    task automatic do_txn(input logic [N-1:0] r, input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                          input int stall, input int exp_id, input logic e, input logic g,
                          input logic l, input string tag);
        int waited;
        req       = r;
        a_in      = av;
        b_in      = bv;
        rsp_ready = (stall == 0);
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 8);
        check({tag, " latency"}, 32'(waited), 32'd1);
        check({tag, " gnt"}, 32'(gnt), 32'(onehot(exp_id)));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " early_valid"}, 32'(rsp_valid), 32'd0);
        req  = '0;
        a_in = rand_lanes();
        b_in = rand_lanes();
        @(negedge clk);
        check({tag, " valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " gnt_off"}, 32'(gnt), 32'd0);
        check({tag, " id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, " result"}, 32'({rsp_equal, rsp_bigger, rsp_less}), 32'({e, g, l}));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " stall_hold"}, 32'({rsp_id, rsp_equal, rsp_bigger, rsp_less}),
                  32'({IDW'(exp_id), e, g, l}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " retain"}, 32'({rsp_equal, rsp_bigger, rsp_less}), 32'({e, g, l}));
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(busy), 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gid[$];
        int gcyc[$];
        logic [N*W-1:0] av;
        logic [N*W-1:0] bv;
        logic [N-1:0]   r;
        int             w;
        int             ea;
        int             eb;

        vecs[0] = '{4'b0001, 4'd9,  4'd3,  0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'b0100, 4'd5,  4'd5,  2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b0100, 4'd0,  4'd15, 2, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{4'b1001, 4'd15, 4'd15, 3, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'b1011, 4'd0,  4'd0,  0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b1010, 4'd1,  4'd0,  1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'b0001, 4'd7,  4'd8,  0, 1'b0, 1'b0, 1'b1};

        // Reset
        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid", 32'(rsp_valid), 32'd0);
        check("rst id", 32'(rsp_id), 32'd0);
        check("rst result", 32'({rsp_equal, rsp_bigger, rsp_less}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            av = put_lane(rand_lanes(), vecs[i].id, vecs[i].a);
            bv = put_lane(rand_lanes(), vecs[i].id, vecs[i].b);
            do_txn(vecs[i].r, av, bv, 0, vecs[i].id, vecs[i].e, vecs[i].g, vecs[i].l,
                   $sformatf("vec%0d", i));
        end

        // Asynchronous reset while COMPARE is in progress
        req       = 4'b0100;
        a_in      = rand_lanes();
        b_in      = rand_lanes();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("midrst gnt_before", 32'(gnt), 32'(4'b0100));
        #2 rst_n = 1'b0;
        #1;
        check("midrst gnt", 32'(gnt), 32'd0);
        check("midrst valid", 32'(rsp_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("midrst valid_hold", 32'(rsp_valid), 32'd0);
        req   = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin fairness with all requesters held high
        req       = 4'b1111;
        a_in      = rand_lanes();
        b_in      = rand_lanes();
        rsp_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                check("rr onehot", 32'($countones(gnt)), 32'd1);
                for (int i = 0; i < N; i++) if (gnt[i]) gid.push_back(i);
                gcyc.push_back(c);
            end
        end
        req = '0;
        check("rr grant_count", 32'(gid.size()), 32'd5);
        if (gid.size() == 5) begin
            check("rr order0", 32'(gid[0]), 32'd0);
            check("rr order1", 32'(gid[1]), 32'd1);
            check("rr order2", 32'(gid[2]), 32'd2);
            check("rr order3", 32'(gid[3]), 32'd3);
            check("rr order4", 32'(gid[4]), 32'd0);
            for (int i = 1; i < 5; i++) check("rr spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        drain();

        // Backpressure with other requests pending
        av        = put_lane(rand_lanes(), 0, 4'd3);
        bv        = put_lane(rand_lanes(), 0, 4'd3);
        req       = 4'b0001;
        a_in      = av;
        b_in      = bv;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp gnt0", 32'(gnt), 32'(4'b0001));
        req = 4'b0110;
        @(negedge clk);
        check("bp valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold", 32'({rsp_valid, rsp_id, rsp_equal, rsp_bigger, rsp_less}),
                  32'({1'b1, 2'd0, 1'b1, 1'b0, 1'b0}));
            check("bp no_gnt", 32'(gnt), 32'd0);
            check("bp busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp released", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("bp next_gnt", 32'(gnt), 32'(4'b0010));
        req = '0;
        drain();
        model_last = 1;

        // Randomized transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            r  = N'($urandom_range(1, (1 << N) - 1));
            av = rand_lanes();
            bv = rand_lanes();
            w  = model_pick(r, model_last);
            ea = int'(get_lane(av, w));
            eb = int'(get_lane(bv, w));
            do_txn(r, av, bv, $urandom_range(0, 3), w, ea == eb, ea > eb, ea < eb,
                   $sformatf("rnd%0d", t));
            model_last = w;
        end

`ifdef CMP_SHARE_ARBITER_STATS_EN
        // Handshake counter and saturation
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("stats reset", 32'(cmp_count), 32'd0);
        for (int i = 0; i < 7; i++) begin
            av = put_lane(rand_lanes(), 0, 4'd2);
            bv = put_lane(rand_lanes(), 0, 4'd1);
            do_txn(4'b0001, av, bv, i % 2, 0, 1'b0, 1'b1, 1'b0, "stats");
        end
        check("stats count7", 32'(cmp_count), 32'd7);
        force dut.stat_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.stat_cnt;
        av = put_lane(rand_lanes(), 0, 4'd2);
        bv = put_lane(rand_lanes(), 0, 4'd1);
        do_txn(4'b0001, av, bv, 0, 0, 1'b0, 1'b1, 1'b0, "stats_sat");
        check("stats saturate", 32'(cmp_count), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
